// File: rtl/bp_io_stream_axil_writer.sv
// Drains BlackParrot I/O command words through a small FIFO, one AXI4-Lite write per word,
// to a fixed mailbox address; counts completed writes and latches any error response.
module bp_io_stream_axil_writer #(
  parameter int fifo_els_p = 4,
  parameter int axil_addr_width_p = 32,
  parameter int axil_data_width_p = 32,
  parameter logic [axil_addr_width_p-1:0] mailbox_addr_p = '0,
  parameter int count_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [31:0]                  data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [axil_addr_width_p-1:0] m_axil_awaddr_o,
  output logic [2:0]                   m_axil_awprot_o,
  output logic                         m_axil_awvalid_o,
  input  logic                         m_axil_awready_i,
  output logic [axil_data_width_p-1:0] m_axil_wdata_o,
  output logic [3:0]                   m_axil_wstrb_o,
  output logic                         m_axil_wvalid_o,
  input  logic                         m_axil_wready_i,
  input  logic [1:0]                   m_axil_bresp_i,
  input  logic                         m_axil_bvalid_i,
  output logic                         m_axil_bready_o,
  output logic [count_width_p-1:0]     sent_count_o,
  output logic                         error_o,
  output logic                         idle_o
);

  localparam int ptr_w = $clog2(fifo_els_p);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_e;

  state_e                   state_reg;
  logic [31:0]              mem [fifo_els_p];
  logic [ptr_w:0]           wptr_reg;
  logic [ptr_w:0]           rptr_reg;
  logic                     awvalid_reg;
  logic                     wvalid_reg;
  logic                     bready_reg;
  logic                     aw_done_reg;
  logic                     w_done_reg;
  logic                     error_reg;
  logic [31:0]              wdata_reg;
  logic [count_width_p-1:0] sent_reg;

  logic full;
  logic empty;
  logic push;
  logic aw_hs;
  logic w_hs;

  // Extra wrap bit tells full from empty when the index bits match.
  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[ptr_w] != rptr_reg[ptr_w]) &&
                 (wptr_reg[ptr_w-1:0] == rptr_reg[ptr_w-1:0]);
  assign push  = v_i & ~full;
  assign aw_hs = awvalid_reg & m_axil_awready_i;
  assign w_hs  = wvalid_reg & m_axil_wready_i;

  assign ready_o          = ~full;
  assign idle_o           = empty && (state_reg == IDLE);
  assign m_axil_awaddr_o  = mailbox_addr_p;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awvalid_reg;
  assign m_axil_wdata_o   = wdata_reg;
  assign m_axil_wstrb_o   = 4'hF;
  assign m_axil_wvalid_o  = wvalid_reg;
  assign m_axil_bready_o  = bready_reg;
  assign sent_count_o     = sent_reg;
  assign error_o          = error_reg;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_reg[ptr_w-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= IDLE;
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      error_reg   <= 1'b0;
      wdata_reg   <= '0;
      sent_reg    <= '0;
    end else begin
      if (push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (!empty) begin
            state_reg   <= SEND;
            awvalid_reg <= 1'b1;
            wvalid_reg  <= 1'b1;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            wdata_reg   <= mem[rptr_reg[ptr_w-1:0]];
          end
        end
        SEND: begin
          // AW and W retire independently; the response phase waits for both.
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
            state_reg  <= RESP;
            bready_reg <= 1'b1;
          end
        end
        RESP: begin
          if (m_axil_bvalid_i) begin
            state_reg  <= IDLE;
            bready_reg <= 1'b0;
            rptr_reg   <= rptr_reg + 1'b1;
            if (sent_reg != '1) begin
              sent_reg <= sent_reg + 1'b1;
            end
            if (m_axil_bresp_i != 2'b00) begin
              error_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_io_stream_axil_writer.sv
// Randomised bench for bp_io_stream_axil_writer: a queue-based reference model is
// compared against the DUT every cycle, plus literal checks on the directed scenarios.
module tb_bp_io_stream_axil_writer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] MBOX  = 32'hA000_0040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic        v = 1'b0;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;

  logic        ready, awvalid, wvalid, bready, error, idle;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awprot;
  logic [3:0]  wstrb;
  logic [15:0] sent;

  logic        s_ready, s_awvalid, s_wvalid, s_bready, s_error, s_idle;
  logic [31:0] s_awaddr, s_wdata;
  logic [2:0]  s_awprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_sent;

  bp_io_stream_axil_writer #(
    .fifo_els_p(DEPTH), .axil_addr_width_p(32), .axil_data_width_p(32),
    .mailbox_addr_p(MBOX), .count_width_p(16)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(data), .v_i(v), .ready_o(ready),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready), .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb),
    .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready), .m_axil_bresp_i(bresp),
    .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready), .sent_count_o(sent),
    .error_o(error), .idle_o(idle)
  );

  // Narrow-counter instance sharing every input, used to observe saturation.
  bp_io_stream_axil_writer #(
    .fifo_els_p(DEPTH), .axil_addr_width_p(32), .axil_data_width_p(32),
    .mailbox_addr_p(MBOX), .count_width_p(2)
  ) dut_sat (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(data), .v_i(v), .ready_o(s_ready),
    .m_axil_awaddr_o(s_awaddr), .m_axil_awprot_o(s_awprot), .m_axil_awvalid_o(s_awvalid),
    .m_axil_awready_i(awready), .m_axil_wdata_o(s_wdata), .m_axil_wstrb_o(s_wstrb),
    .m_axil_wvalid_o(s_wvalid), .m_axil_wready_i(wready), .m_axil_bresp_i(bresp),
    .m_axil_bvalid_i(bvalid), .m_axil_bready_o(s_bready), .sent_count_o(s_sent),
    .error_o(s_error), .idle_o(s_idle)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Reference model: queue of words held, plus which handshakes are still owed.
  logic [31:0] mq[$];
  bit          m_aw = 0, m_w = 0, m_b = 0, m_err = 0;
  int          m_sent = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_aw = 0; m_w = 0; m_b = 0; m_err = 0; m_sent = 0;
    end else begin
      int  old_n;
      bit  do_push;
      old_n   = mq.size();
      do_push = v && (old_n < DEPTH);
      if (m_b) begin
        if (bvalid) begin
          void'(mq.pop_front());
          m_sent++;
          if (bresp != 2'b00) m_err = 1;
          m_b = 0;
        end
      end else if (m_aw || m_w) begin
        if (m_aw && awready) m_aw = 0;
        if (m_w && wready) m_w = 0;
        if (!m_aw && !m_w) m_b = 1;
      end else if (old_n > 0) begin
        m_aw = 1;
        m_w  = 1;
      end
      if (do_push) mq.push_back(data);
    end
  end

  // Compare every cycle against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("ready", ready, (mq.size() < DEPTH));
      chk("awvalid", awvalid, m_aw);
      chk("wvalid", wvalid, m_w);
      chk("bready", bready, m_b);
      chk("idle", idle, (mq.size() == 0) && !m_aw && !m_w && !m_b);
      chk("sent_count", sent, m_sent);
      chk("error", error, m_err);
      chk("sat_count", s_sent, (m_sent > 3) ? 3 : m_sent);
      chk("sat_awvalid", s_awvalid, m_aw);
      chk("sat_error", s_error, m_err);
      chk("awprot", awprot, 0);
      chk("wstrb", wstrb, 4'hF);
      if (m_aw) chk("awaddr", awaddr, MBOX);
      if (m_w && mq.size() > 0) chk("wdata", wdata, mq[0]);
    end
  end

  // AXI-Lite slave: random readiness; a B response is owed once AW and W both complete.
  int aw_prob = 100, w_prob = 100, b_prob = 100, err_pct = 0, err_at = -1, b_total = 0;
  bit aw_got = 0, w_got = 0, b_owed = 0;

  initial forever begin
    @(negedge rst_n);
    aw_got = 0; w_got = 0; b_owed = 0;
  end

  initial forever begin
    @(negedge clk);
    awready = (int'($urandom_range(99)) < aw_prob);
    wready  = (int'($urandom_range(99)) < w_prob);
    bvalid  = b_owed && (int'($urandom_range(99)) < b_prob);
    bresp   = ((b_total == err_at) || (int'($urandom_range(99)) < err_pct)) ? 2'b10 : 2'b00;
    // Values are now stable until the next posedge: account for that edge's handshakes.
    if (rst_n) begin
      if (awvalid && awready) aw_got = 1;
      if (wvalid && wready) w_got = 1;
      if (bvalid && bready) begin
        b_owed = 0;
        b_total++;
      end
      if (aw_got && w_got) begin
        b_owed = 1;
        aw_got = 0;
        w_got  = 0;
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    bit ok;
    ok   = 0;
    v    = 1'b1;
    data = w;
    for (int k = 0; k < 400; k++) begin
      if (ready === 1'b1) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    v = 1'b0;
    if (!ok) timeout("push");
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (idle === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("wait_idle");
  endtask

  logic [1:0] sat_exp [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_count", sent, 0);
    chk("rst_error", error, 0);

    // Single write: valid one cycle after the push edge.
    push_word(32'h8012_34A5);
    @(negedge clk);
    chk("first_awvalid", awvalid, 1);
    chk("first_wvalid", wvalid, 1);
    chk("first_wdata", wdata, 32'h8012_34A5);
    chk("first_awaddr", awaddr, 32'hA000_0040);
    wait_idle(50);
    chk("first_count", sent, 1);
    chk("first_idle", idle, 1);
    chk("first_sat", s_sent, 1);

    for (int i = 0; i < 4; i++) begin
      push_word($urandom);
      wait_idle(50);
      chk("sat_seq", s_sent, sat_exp[i]);
      chk("sat_main", sent, i + 2);
    end

    // Back-pressure: fill the FIFO with AXI stalled, hold a fifth word.
    aw_prob = 0;
    w_prob  = 0;
    for (int i = 0; i < 4; i++) push_word(32'h1000_0000 + i);
    chk("full_ready", ready, 0);
    v    = 1'b1;
    data = 32'h8000_0005;
    repeat (5) @(negedge clk);
    chk("held_ready", ready, 0);
    aw_prob = 100;
    w_prob  = 100;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (ready === 1'b1) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    v = 1'b0;
    if (!ok) timeout("held_push");
    wait_idle(200);
    chk("burst_count", sent, 10);

    // Skewed handshakes: AW first, W first, then together.
    for (int m = 0; m < 3; m++) begin
      aw_prob = (m == 1) ? 0 : 100;
      w_prob  = (m == 0) ? 0 : 100;
      push_word(32'hC000_0000 + m);
      repeat (4) @(negedge clk);
      if (m < 2) begin
        chk("skew_awvalid", awvalid, (m == 0) ? 0 : 1);
        chk("skew_wvalid", wvalid, (m == 0) ? 1 : 0);
        chk("skew_bready", bready, 0);
      end
      aw_prob = 100;
      w_prob  = 100;
      wait_idle(50);
    end
    chk("skew_count", sent, 13);

    // Error response on the second of three writes.
    err_at = b_total + 1;
    for (int i = 0; i < 3; i++) push_word(32'h8ABC_0000 + i);
    wait_idle(200);
    err_at = -1;
    chk("err_flag", error, 1);
    chk("err_count", sent, 16);

    // Reset while a write is in flight with two words queued.
    aw_prob = 0;
    w_prob  = 0;
    push_word(32'h8111_1111);
    push_word(32'h8222_2222);
    @(negedge clk);
    chk("pre_rst_awvalid", awvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_awvalid", awvalid, 0);
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_count", sent, 0);
    chk("rst_mid_error", error, 0);
    chk("rst_mid_sat", s_sent, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    aw_prob = 100;
    w_prob  = 100;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_idle", idle, 1);
    push_word(32'h8765_4321);
    wait_idle(50);
    chk("post_rst_count", sent, 1);

    // Randomised traffic with random stalls, gaps and occasional error responses.
    err_pct = 5;
    for (int n = 0; n < 150; n++) begin
      if (n % 16 == 0) begin
        aw_prob = $urandom_range(10, 100);
        w_prob  = $urandom_range(10, 100);
        b_prob  = $urandom_range(20, 100);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_word($urandom);
    end
    wait_idle(3000);
    chk("rand_count", sent, 151);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
